// File: rtl/halflife_decay_counter.sv
// ----------------------------------------------------------------------------
// halflife_decay_counter
//
// WIDTH-bit counter with a built-in prescaler. Every PRESCALE enabled cycles a
// tick strobe fires and the selected mode operation is applied:
//   mode 00 wrap     : up/down modulo 2^WIDTH, tc after a wrap
//   mode 01 saturate : up/down clamped at max/0, tc on first arrival at a bound
//   mode 10 halve    : count >>= 1, halvings counts nonzero halvings, tc at 1->0
//   mode 11 hold     : count frozen, prescaler keeps running
// A load is ungated by en/tick and restarts the prescaler.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (overrides everything)
//   en       in   prescaler enable
//   load     in   load load_val into count (clears halvings/prescaler/tc)
//   load_val in   [WIDTH-1:0] value to load
//   up       in   increment request (wrap/saturate)
//   down     in   decrement request (wrap/saturate); up&down = no-op
//   mode     in   [1:0] operating mode
//   count    out  [WIDTH-1:0] registered count
//   zero     out  count == 0 (combinational)
//   at_max   out  count == 2^WIDTH-1 (combinational)
//   tc       out  registered one-cycle terminal-count pulse
//   halvings out  [HW-1:0] registered nonzero-halving count, saturating
//   tick     out  prescaler tick strobe (combinational)
// ----------------------------------------------------------------------------
module halflife_decay_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4,
    parameter int HW       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             down,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             at_max,
    output logic             tc,
    output logic [HW-1:0]    halvings,
    output logic             tick
);

    // A 1-bit prescaler is kept even for PRESCALE=1; it then stays at 0 and
    // the tick degenerates to en.
    localparam int               PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PS_LAST   = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PS_ONE    = PW'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MAXM1 = CNT_MAX - CNT_ONE;
    localparam logic [HW-1:0]    HALV_ONE  = HW'(1);
    localparam logic [HW-1:0]    HALV_MAX  = {HW{1'b1}};

    localparam logic [1:0] MODE_WRAP  = 2'b00;
    localparam logic [1:0] MODE_SAT   = 2'b01;
    localparam logic [1:0] MODE_HALVE = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    logic [PW-1:0]    r_prescale;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic [HW-1:0]    r_halvings;

    logic             w_tick;
    logic             w_up_only;
    logic             w_down_only;
    logic [PW-1:0]    w_next_prescale;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_tc;
    logic [HW-1:0]    w_next_halvings;

    assign w_tick      = en & (r_prescale == PS_LAST);
    assign w_up_only   = up & ~down;
    assign w_down_only = down & ~up;

    // Prescaler next state: a load restarts it, en gates its advance.
    always_comb begin
        w_next_prescale = r_prescale;
        if (load) begin
            w_next_prescale = {PW{1'b0}};
        end else if (en) begin
            if (w_tick) begin
                w_next_prescale = {PW{1'b0}};
            end else begin
                w_next_prescale = r_prescale + PS_ONE;
            end
        end else begin
            w_next_prescale = r_prescale;
        end
    end

    // Count / tc / halvings next state; tc defaults low so it is a pulse.
    always_comb begin
        w_next_count    = r_count;
        w_next_tc       = 1'b0;
        w_next_halvings = r_halvings;
        if (load) begin
            w_next_count    = load_val;
            w_next_halvings = {HW{1'b0}};
        end else if (w_tick) begin
            case (mode)
                MODE_WRAP: begin
                    if (w_up_only) begin
                        w_next_count = r_count + CNT_ONE;
                        w_next_tc    = (r_count == CNT_MAX);
                    end else if (w_down_only) begin
                        w_next_count = r_count - CNT_ONE;
                        w_next_tc    = (r_count == CNT_ZERO);
                    end else begin
                        w_next_count = r_count;
                    end
                end
                MODE_SAT: begin
                    // tc only on arrival at the bound, never while parked on it.
                    if (w_up_only && (r_count != CNT_MAX)) begin
                        w_next_count = r_count + CNT_ONE;
                        w_next_tc    = (r_count == CNT_MAXM1);
                    end else if (w_down_only && (r_count != CNT_ZERO)) begin
                        w_next_count = r_count - CNT_ONE;
                        w_next_tc    = (r_count == CNT_ONE);
                    end else begin
                        w_next_count = r_count;
                    end
                end
                MODE_HALVE: begin
                    w_next_count = r_count >> 1;
                    w_next_tc    = (r_count == CNT_ONE);
                    if ((r_count != CNT_ZERO) && (r_halvings != HALV_MAX)) begin
                        w_next_halvings = r_halvings + HALV_ONE;
                    end else begin
                        w_next_halvings = r_halvings;
                    end
                end
                MODE_HOLD: begin
                    w_next_count = r_count;
                end
                default: begin
                    w_next_count = r_count;
                end
            endcase
        end else begin
            w_next_count = r_count;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale <= {PW{1'b0}};
            r_count    <= {WIDTH{1'b0}};
            r_tc       <= 1'b0;
            r_halvings <= {HW{1'b0}};
        end else begin
            r_prescale <= w_next_prescale;
            r_count    <= w_next_count;
            r_tc       <= w_next_tc;
            r_halvings <= w_next_halvings;
        end
    end

    assign count    = r_count;
    assign tc       = r_tc;
    assign halvings = r_halvings;
    assign tick     = w_tick;
    assign zero     = (r_count == CNT_ZERO);
    assign at_max   = (r_count == CNT_MAX);

endmodule

// File: tb/tb_halflife_decay_counter.sv
module tb_halflife_decay_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic [1:0] mode = 2'b00;

    // index 0: PRESCALE=4 instance, index 1: PRESCALE=1 instance
    logic [7:0] cnt_o  [2];
    logic       zero_o [2];
    logic       max_o  [2];
    logic       tc_o   [2];
    logic [3:0] halv_o [2];
    logic       tick_o [2];

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    int m_cnt  [2];
    int m_halv [2];
    int m_tc   [2];
    int m_ec   [2];  // enabled cycles since last load/reset

    localparam logic [7:0] HALF_SEQ [8] = '{8'h5A, 8'h2D, 8'h16, 8'h0B, 8'h05, 8'h02, 8'h01, 8'h00};

    always #5 clk = ~clk;

    halflife_decay_counter #(.WIDTH(8), .PRESCALE(4), .HW(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .up(up), .down(down), .mode(mode),
        .count(cnt_o[0]), .zero(zero_o[0]), .at_max(max_o[0]), .tc(tc_o[0]),
        .halvings(halv_o[0]), .tick(tick_o[0])
    );

    halflife_decay_counter #(.WIDTH(8), .PRESCALE(1), .HW(4)) dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .up(up), .down(down), .mode(mode),
        .count(cnt_o[1]), .zero(zero_o[1]), .at_max(max_o[1]), .tc(tc_o[1]),
        .halvings(halv_o[1]), .tick(tick_o[1])
    );

    function automatic int presc_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic bit model_tick(int i);
        return en && (((m_ec[i] + 1) % presc_of(i)) == 0);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit tk;
            tk = model_tick(i);
            if (rst) begin
                m_cnt[i] = 0; m_halv[i] = 0; m_tc[i] = 0; m_ec[i] = 0;
            end else if (load) begin
                m_cnt[i] = int'(load_val); m_halv[i] = 0; m_tc[i] = 0; m_ec[i] = 0;
            end else begin
                m_tc[i] = 0;
                if (en) m_ec[i]++;
                if (tk) begin
                    case (mode)
                        2'b00: begin
                            if (up && !down) begin
                                m_tc[i] = (m_cnt[i] == 255) ? 1 : 0;
                                m_cnt[i] = (m_cnt[i] + 1) % 256;
                            end else if (down && !up) begin
                                m_tc[i] = (m_cnt[i] == 0) ? 1 : 0;
                                m_cnt[i] = (m_cnt[i] + 255) % 256;
                            end
                        end
                        2'b01: begin
                            if (up && !down && m_cnt[i] < 255) begin
                                m_cnt[i] = m_cnt[i] + 1;
                                m_tc[i] = (m_cnt[i] == 255) ? 1 : 0;
                            end else if (down && !up && m_cnt[i] > 0) begin
                                m_cnt[i] = m_cnt[i] - 1;
                                m_tc[i] = (m_cnt[i] == 0) ? 1 : 0;
                            end
                        end
                        2'b10: begin
                            m_tc[i] = (m_cnt[i] == 1) ? 1 : 0;
                            if (m_cnt[i] != 0 && m_halv[i] < 15) m_halv[i] = m_halv[i] + 1;
                            m_cnt[i] = m_cnt[i] / 2;
                        end
                        default: ;
                    endcase
                end
            end
        end
    endtask

    // Apply a one-cycle load at the current negedge, return at the next negedge.
    task automatic do_load(input logic [7:0] v, input logic [1:0] m, input logic u, input logic d);
        load = 1'b1; load_val = v; mode = m; up = u; down = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; load_val = 8'hAA; en = 1'b1; up = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_total++; if (cnt_o[i] !== 8'h00) $display("FAIL reset_count[%0d] got=%h exp=00", i, cnt_o[i]); else n_pass++;
            n_total++; if (halv_o[i] !== 4'h0) $display("FAIL reset_halvings[%0d] got=%h exp=0", i, halv_o[i]); else n_pass++;
            n_total++; if (tc_o[i] !== 1'b0) $display("FAIL reset_tc[%0d] got=%b exp=0", i, tc_o[i]); else n_pass++;
            n_total++; if (zero_o[i] !== 1'b1) $display("FAIL reset_zero[%0d] got=%b exp=1", i, zero_o[i]); else n_pass++;
        end
        rst = 1'b0; load = 1'b0; up = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_c;
        en = 1'b1;
        do_load(8'hFE, 2'b00, 1'b1, 1'b0);
        n_total++; if (cnt_o[0] !== 8'hFE) $display("FAIL wrap_load count got=%h exp=FE", cnt_o[0]); else n_pass++;
        for (int i = 1; i <= 9; i++) begin
            n_total++; if (tick_o[0] !== (i % 4 == 0)) $display("FAIL wrap_tick cyc=%0d got=%b exp=%b", i, tick_o[0], (i % 4 == 0)); else n_pass++;
            @(negedge clk);
            exp_c = (i < 4) ? 8'hFE : ((i < 8) ? 8'hFF : 8'h00);
            n_total++; if (cnt_o[0] !== exp_c) $display("FAIL wrap_count cyc=%0d got=%h exp=%h", i, cnt_o[0], exp_c); else n_pass++;
            n_total++; if (tc_o[0] !== (i == 8)) $display("FAIL wrap_tc cyc=%0d got=%b exp=%b", i, tc_o[0], (i == 8)); else n_pass++;
        end
        up = 1'b0;
    endtask

    task automatic test_sat_down();
        logic [7:0] exp_c;
        do_load(8'h02, 2'b01, 1'b0, 1'b1);
        n_total++; if (cnt_o[1] !== 8'h02) $display("FAIL sat_load count got=%h exp=02", cnt_o[1]); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_c = (i == 0) ? 8'h01 : 8'h00;
            n_total++; if (cnt_o[1] !== exp_c) $display("FAIL sat_count step=%0d got=%h exp=%h", i, cnt_o[1], exp_c); else n_pass++;
            n_total++; if (tc_o[1] !== (i == 1)) $display("FAIL sat_tc step=%0d got=%b exp=%b", i, tc_o[1], (i == 1)); else n_pass++;
            n_total++; if (zero_o[1] !== (i >= 1)) $display("FAIL sat_zero step=%0d got=%b exp=%b", i, zero_o[1], (i >= 1)); else n_pass++;
        end
        down = 1'b0;
    endtask

    task automatic test_halve();
        logic [7:0] exp_c;
        logic [3:0] exp_h;
        int tc_seen = 0;
        do_load(8'hB4, 2'b10, 1'b0, 1'b0);
        n_total++; if (halv_o[0] !== 4'h0) $display("FAIL halve_load halvings got=%h exp=0", halv_o[0]); else n_pass++;
        for (int k = 0; k < 10; k++) begin
            repeat (4) begin
                @(negedge clk);
                if (tc_o[0] === 1'b1) tc_seen++;
            end
            exp_c = (k < 8) ? HALF_SEQ[k] : 8'h00;
            exp_h = (k < 8) ? 4'(k + 1) : 4'd8;
            n_total++; if (cnt_o[0] !== exp_c) $display("FAIL halve_count k=%0d got=%h exp=%h", k, cnt_o[0], exp_c); else n_pass++;
            n_total++; if (halv_o[0] !== exp_h) $display("FAIL halve_halvings k=%0d got=%0d exp=%0d", k, halv_o[0], exp_h); else n_pass++;
            n_total++; if (tc_o[0] !== (k == 7)) $display("FAIL halve_tc k=%0d got=%b exp=%b", k, tc_o[0], (k == 7)); else n_pass++;
        end
        n_total++; if (tc_seen != 1) $display("FAIL halve_tc_pulses got=%0d exp=1", tc_seen); else n_pass++;
    endtask

    task automatic test_priority();
        do_load(8'h37, 2'b00, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        n_total++; if (cnt_o[0] !== 8'h37) $display("FAIL updown_both count got=%h exp=37", cnt_o[0]); else n_pass++;
        do_load(8'h80, 2'b10, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        n_total++; if (cnt_o[0] !== 8'h40) $display("FAIL prio_pre count got=%h exp=40", cnt_o[0]); else n_pass++;
        n_total++; if (halv_o[0] !== 4'h1) $display("FAIL prio_pre halvings got=%h exp=1", halv_o[0]); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (tick_o[0] !== 1'b1) $display("FAIL prio_tick_before_load got=%b exp=1", tick_o[0]); else n_pass++;
        load = 1'b1; load_val = 8'h64;
        @(negedge clk);
        load = 1'b0;
        n_total++; if (cnt_o[0] !== 8'h64) $display("FAIL prio_load count got=%h exp=64", cnt_o[0]); else n_pass++;
        n_total++; if (halv_o[0] !== 4'h0) $display("FAIL prio_load halvings got=%h exp=0", halv_o[0]); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (cnt_o[0] !== 8'h64) $display("FAIL prio_restart count got=%h exp=64", cnt_o[0]); else n_pass++;
        n_total++; if (tick_o[0] !== 1'b1) $display("FAIL prio_restart tick got=%b exp=1", tick_o[0]); else n_pass++;
        @(negedge clk);
        n_total++; if (cnt_o[0] !== 8'h32) $display("FAIL prio_next_tick count got=%h exp=32", cnt_o[0]); else n_pass++;
        n_total++; if (halv_o[0] !== 4'h1) $display("FAIL prio_next_tick halvings got=%h exp=1", halv_o[0]); else n_pass++;
    endtask

    task automatic test_en_hold();
        int ticks = 0;
        do_load(8'h10, 2'b00, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (tick_o[0] === 1'b1) ticks++;
            @(negedge clk);
        end
        n_total++; if (ticks != 0) $display("FAIL en_off ticks got=%0d exp=0", ticks); else n_pass++;
        n_total++; if (cnt_o[0] !== 8'h10) $display("FAIL en_off count got=%h exp=10", cnt_o[0]); else n_pass++;
        en = 1'b1;
        #1;
        n_total++; if (tick_o[0] !== 1'b0) $display("FAIL en_resume tick0 got=%b exp=0", tick_o[0]); else n_pass++;
        @(negedge clk);
        n_total++; if (tick_o[0] !== 1'b1) $display("FAIL en_resume tick1 got=%b exp=1", tick_o[0]); else n_pass++;
        n_total++; if (cnt_o[0] !== 8'h10) $display("FAIL en_resume count0 got=%h exp=10", cnt_o[0]); else n_pass++;
        @(negedge clk);
        n_total++; if (cnt_o[0] !== 8'h11) $display("FAIL en_resume count1 got=%h exp=11", cnt_o[0]); else n_pass++;
        mode = 2'b11;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            if (tick_o[0] === 1'b1) ticks++;
            @(negedge clk);
        end
        n_total++; if (ticks != 2) $display("FAIL hold_ticks got=%0d exp=2", ticks); else n_pass++;
        n_total++; if (cnt_o[0] !== 8'h11) $display("FAIL hold_count got=%h exp=11", cnt_o[0]); else n_pass++;
        up = 1'b0;
    endtask

    task automatic test_random();
        int sel;
        rst = 1'b1; load = 1'b0;
        model_step();
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 800; n++) begin
            rst  = ($urandom_range(0, 99) == 0);
            load = ($urandom_range(0, 24) == 0);
            sel  = $urandom_range(0, 5);
            load_val = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h01 : (sel == 2) ? 8'hFE :
                       (sel == 3) ? 8'hFF : 8'($urandom);
            up   = 1'($urandom);
            down = 1'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            en   = ($urandom_range(0, 7) != 0);
            #1;
            for (int i = 0; i < 2; i++) begin
                n_total++; if (tick_o[i] !== model_tick(i)) $display("FAIL rnd_tick[%0d] n=%0d got=%b exp=%b", i, n, tick_o[i], model_tick(i)); else n_pass++;
            end
            model_step();
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_total++; if (cnt_o[i] !== 8'(m_cnt[i])) $display("FAIL rnd_count[%0d] n=%0d got=%h exp=%h", i, n, cnt_o[i], 8'(m_cnt[i])); else n_pass++;
                n_total++; if (tc_o[i] !== 1'(m_tc[i])) $display("FAIL rnd_tc[%0d] n=%0d got=%b exp=%b", i, n, tc_o[i], 1'(m_tc[i])); else n_pass++;
                n_total++; if (halv_o[i] !== 4'(m_halv[i])) $display("FAIL rnd_halvings[%0d] n=%0d got=%0d exp=%0d", i, n, halv_o[i], m_halv[i]); else n_pass++;
                n_total++; if (zero_o[i] !== (m_cnt[i] == 0)) $display("FAIL rnd_zero[%0d] n=%0d got=%b exp=%b", i, n, zero_o[i], (m_cnt[i] == 0)); else n_pass++;
                n_total++; if (max_o[i] !== (m_cnt[i] == 255)) $display("FAIL rnd_at_max[%0d] n=%0d got=%b exp=%b", i, n, max_o[i], (m_cnt[i] == 255)); else n_pass++;
            end
        end
        rst = 1'b0; load = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_wrap();
        test_sat_down();
        test_halve();
        test_priority();
        test_en_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/halflife_decay_counter.md
Name: halflife_decay_counter

Overview:
- Parametrised successor to the 4-bit up/down/load counter: WIDTH-bit counter with a built-in prescaler and selectable wrap, saturate, half-life (halve-per-tick) and hold modes.
- Provides zero/max status flags, a one-cycle terminal-count pulse and a halvings counter.
- Sits between the TinyTapeout user I/O and display/decode logic as the core timing element of the half-life timer.

Parameters:
- WIDTH, 8, counter width in bits (≥2).
- PRESCALE, 4, clock cycles per count tick (≥1; 1 = tick every enabled cycle).
- HW, 4, width of halvings counter; must satisfy 2^HW-1 ≥ WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  prescaler enable; when low, the prescaler and tick-gated operations freeze.
- load  input  1  load load_val into count.
- load_val  input  WIDTH  value to load.
- up  input  1  increment request (wrap/saturate modes).
- down  input  1  decrement request (wrap/saturate modes).
- mode  input  2  operating mode: 00 wrap, 01 saturate, 10 halve, 11 hold.
- count  output  WIDTH  registered counter value.
- zero  output  1  combinational, (count == 0).
- at_max  output  1  combinational, (count == 2^WIDTH-1).
- tc  output  1  registered one-cycle terminal-count pulse.
- halvings  output  HW  registered number of nonzero halvings since the last load or reset.
- tick  output  1  combinational prescaler tick strobe.

Behaviour:
- Reset (rst=1 at a clock edge): count=0, halvings=0, prescaler=0, tc=0. rst overrides every other input.
- Prescaler: internal counter 0..PRESCALE-1, advances only when en=1. tick = en & (prescaler == PRESCALE-1), and the prescaler wraps to 0 on that cycle. If PRESCALE=1, tick = en.
- Priority per edge: rst > load > tick-gated mode operation > hold.
- Load:
  - Ungated by tick or en.
  - count <= load_val, halvings <= 0, prescaler <= 0, tc <= 0.
  - The next tick occurs PRESCALE enabled cycles after the load.
- Tick-gated operations (only when tick=1, no load, no rst). up and down both high is treated as neither.
- mode 00 (wrap):
  - up: count+1 mod 2^WIDTH.
  - down: count-1 mod 2^WIDTH.
  - tc=1 on the cycle after a wrap (max→0 on up, 0→max on down).
- mode 01 (saturate):
  - up at max holds max; down at 0 holds 0.
  - tc=1 on the cycle after count first reaches the boundary (a transition into max via up, or into 0 via down).
  - Holding at the boundary does not re-pulse tc.
- mode 10 (halve):
  - up/down ignored; count <= count >> 1 (logical).
  - If count != 0 before the shift, halvings increments, saturating at 2^HW-1.
  - tc=1 on the cycle after a 1→0 transition.
  - count=0 remains 0 with no tc.
- mode 11 (hold): count unchanged; the prescaler still runs and tick still asserts.
- tc is high for exactly one cycle per event and is otherwise 0.
- halvings is unchanged in modes 00, 01 and 11.
- A mode change takes effect at the next tick. Changing mode does not touch the prescaler or halvings.
- Latency: count, tc and halvings update on the same edge where tick/load is sampled and are visible the following cycle. zero, at_max and tick are combinational from registered state plus en.
- rst mid-prescale discards the partial prescale count.

Test Plan:
- Reset: rst=1 for 2 cycles with load=1, load_val=0xAA → count=0, halvings=0, tc=0; zero=1.
- Wrap up with prescale (WIDTH=8, PRESCALE=4, en=1):
  - load 0xFE, mode=00, up=1 → count 0xFF after 4 cycles, 0x00 after 8 cycles.
  - tc high exactly 1 cycle, on the cycle after the 0xFF→0x00 transition.
  - tick asserts every 4th cycle.
- Saturate down: load 0x02, mode=01, down=1, PRESCALE=1 → count 1, 0, 0, 0; single tc pulse after the 1→0 transition; zero=1 held.
- Half-life decay:
  - load 0xB4, mode=10 → count 0x5A, 0x2D, 0x16, 0x0B, 0x05, 0x02, 0x01, 0x00.
  - halvings reaches 8 and then stays at 8.
  - tc pulses once after 0x01→0x00.
- Priority/simultaneous events:
  - up=down=1 in mode 00 → count unchanged.
  - load=1 coincident with a tick in mode 10 → count=load_val, halvings=0, prescaler restarts (next tick after PRESCALE cycles).
- en/hold: en=0 for 10 cycles mid-prescale → count and prescaler frozen, tick=0. Then mode=11, en=1 → tick pulses, count constant.
